// File: rtl/plic_axil_master_pkg.sv
// Shared types and constants for the PLIC-side AXI4-Lite master bridge.
package plic_axil_master_pkg;

   // Bridge FSM states; one transaction in flight at most.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_ADDR = 3'd3,
      S_RD_DATA = 3'd4,
      S_RESP    = 3'd5
   } state_e;

   // AXI response codes.
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Unprivileged, secure, data access.
   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // SLVERR and DECERR both report as an error to the core.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/plic_axil_master.sv
// AXI4-Lite master bridge: one core load/store at a time becomes one AXI-Lite
// transaction; requests outside the address window are answered locally with
// an error and never reach the bus.
//
// Handshake rules: a VALID output, once raised, is held with stable
// address/data until the matching READY is seen high on a clock edge; the
// transfer happens on that edge. req_valid/req_ready follow the same rule
// (accept = req_valid & req_ready on an edge). rsp_valid is a one-cycle pulse
// the core cannot stall.
module plic_axil_master
   import plic_axil_master_pkg::*;
#(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR          = 32'h0C00_0000,
   parameter logic [31:0] WINDOW_SIZE        = 32'h0400_0000
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   // Core request side
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     req_addr,
   input  logic [31:0]                       req_wdata,
   input  logic [3:0]                        req_wstrb,
   // Core response side
   output logic                              rsp_valid,
   output logic [31:0]                       rsp_rdata,
   output logic                              rsp_err,
   // AXI write address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   // AXI write data channel
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   // AXI write response channel
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   // AXI read address channel
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   // AXI read data channel
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY,
   // Debug view of the FSM
   output state_e                            dbg_state
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   state_e                state_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic [AW-1:0]         awaddr_q;
   logic [AW-1:0]         araddr_q;
   logic [DW-1:0]         wdata_q;
   logic [DW/8-1:0]       wstrb_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  bready_q;
   logic                  arvalid_q;
   logic                  rready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rdata_q;
   logic                  err_q;

   logic [AW-1:0]         addr_aligned;
   logic [AW-1:0]         addr_offset;
   logic                  in_window;
   logic                  aw_hs;
   logic                  w_hs;

   // Word-align the address and test it against the window; the offset
   // subtraction wraps for addresses below the base, so one compare covers both
   // ends of the window.
   always_comb begin
      addr_aligned = {req_addr[AW-1:2], 2'b00};
      addr_offset  = req_addr - BASE_ADDR[AW-1:0];
      in_window    = (addr_offset < WINDOW_SIZE[AW-1:0]);
      aw_hs        = awvalid_q & M_AXI_AWREADY;
      w_hs         = wvalid_q & M_AXI_WREADY;
   end

   // Transaction FSM with all bus and response outputs registered.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= S_IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b0;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  if (!in_window) begin
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else if (req_we) begin
                     awaddr_q  <= addr_aligned;
                     wdata_q   <= req_wdata;
                     wstrb_q   <= req_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR;
                  end else begin
                     araddr_q  <= addr_aligned;
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_ADDR;
                  end
               end
            end
            S_WR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (M_AXI_BVALID) begin
                  bready_q    <= 1'b0;
                  err_q       <= resp_is_err(M_AXI_BRESP);
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RD_ADDR: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (M_AXI_RVALID) begin
                  rready_q    <= 1'b0;
                  err_q       <= resp_is_err(M_AXI_RRESP);
                  rdata_q     <= resp_is_err(M_AXI_RRESP) ? 32'h0 : M_AXI_RDATA[31:0];
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Output mapping; req_ready is the only output decoded from state.
   always_comb begin
      req_ready     = (state_q == S_IDLE);
      rsp_valid     = rsp_valid_q;
      rsp_rdata     = rdata_q;
      rsp_err       = err_q;
      M_AXI_AWADDR  = awaddr_q;
      M_AXI_AWPROT  = PROT_DEFAULT;
      M_AXI_AWVALID = awvalid_q;
      M_AXI_WDATA   = wdata_q;
      M_AXI_WSTRB   = wstrb_q;
      M_AXI_WVALID  = wvalid_q;
      M_AXI_BREADY  = bready_q;
      M_AXI_ARADDR  = araddr_q;
      M_AXI_ARPROT  = PROT_DEFAULT;
      M_AXI_ARVALID = arvalid_q;
      M_AXI_RREADY  = rready_q;
      dbg_state     = state_q;
   end

endmodule

// File: tb/tb_plic_axil_master.sv
// Self-checking bench for plic_axil_master with a configurable AXI-Lite slave model.
module tb_plic_axil_master;

  localparam logic [31:0] BASE = 32'h0C00_0000;
  localparam logic [31:0] WIN  = 32'h0400_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] awaddr, araddr, wdata, rdata_drv;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [2:0]  dbg_state;

  plic_axil_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata_drv), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- slave configuration and monitor counters ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  int          awv_cycles = 0, wv_cycles = 0, arv_cycles = 0;
  int          b_hs_cnt = 0, ar_hs_cnt = 0, rsp_cnt = 0;
  logic [31:0] aw_seen = '0, ar_seen = '0, w_seen = '0;
  logic [3:0]  ws_seen = '0;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard queues: pushed when a request is driven, popped at its response.
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];

  // AXI-Lite slave: observe handshakes on the rising edge, drive on the falling edge.
  initial begin : slave
    int  aw_cnt, w_cnt, ar_cnt;
    bit  aw_hs, w_hs, b_pend, r_pend;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_hs = 0; w_hs = 0; b_pend = 0; r_pend = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_hs = 0; w_hs = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (rsp_valid) rsp_cnt++;
        if (awvalid) awv_cycles++;
        if (wvalid) wv_cycles++;
        if (arvalid) arv_cycles++;
        if (bvalid && bready) begin b_pend = 0; b_hs_cnt++; end
        if (rvalid && rready) r_pend = 0;
        if (awvalid && awready) begin aw_hs = 1; aw_seen = awaddr; aw_cnt = 0; end
        else if (awvalid) aw_cnt++;
        if (wvalid && wready) begin w_hs = 1; w_seen = wdata; ws_seen = wstrb; w_cnt = 0; end
        else if (wvalid) w_cnt++;
        if (aw_hs && w_hs) begin b_pend = 1; aw_hs = 0; w_hs = 0; end
        if (arvalid && arready) begin r_pend = 1; ar_seen = araddr; ar_hs_cnt++; ar_cnt = 0; end
        else if (arvalid) ar_cnt++;
      end
      @(negedge clk);
      awready   = rst_n && awvalid && (aw_cnt >= aw_delay) && !aw_hs;
      wready    = rst_n && wvalid && (w_cnt >= w_delay) && !w_hs;
      arready   = rst_n && arvalid && (ar_cnt >= ar_delay);
      bvalid    = rst_n && b_pend;
      bresp     = b_pend ? b_resp_cfg : 2'b00;
      rvalid    = rst_n && r_pend;
      rresp     = r_pend ? r_resp_cfg : 2'b00;
      rdata_drv = r_pend ? r_data_cfg : 32'h0;
    end
  end

  // ---------------- driver ----------------
  // Called 1 time unit after a rising edge with the bridge idle; returns in
  // the cycle after the response so the next request can follow directly.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int lat, output logic [31:0] rd,
                        output logic err);
    int cyc;
    bit got;
    req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; got = 0; rd = '0; err = 1'b0;
    while (!got && cyc < 200) begin
      if (rsp_valid) begin got = 1; rd = rsp_rdata; err = rsp_err; end
      else begin @(posedge clk); #1; cyc++; end
    end
    lat = cyc;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout addr=%h no rsp_valid within %0d cycles", addr, cyc);
    end
    @(posedge clk); #1;
  endtask

  // Pops the scoreboard entry for one transaction and compares it inline.
  task automatic score(input string name, input int lat, input logic [31:0] rd, input logic err);
    logic [31:0] e_rd; logic e_err; int e_lat;
    e_rd = exp_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
    vectors++;
    if (rd !== e_rd) begin miscompares++; $display("FAIL %s rdata got %h want %h", name, rd, e_rd); end
    vectors++;
    if (err !== e_err) begin miscompares++; $display("FAIL %s err got %b want %b", name, err, e_err); end
    vectors++;
    if (lat !== e_lat) begin miscompares++; $display("FAIL %s latency got %0d want %0d", name, lat, e_lat); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      miscompares++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata);
    end
    vectors++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_handshake got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    vectors++;
    if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
      miscompares++; $display("FAIL reset_fields aw=%h ar=%h wd=%h ws=%h want 0", awaddr, araddr, wdata, wstrb);
    end
  endtask

  task automatic test_read_zero_wait();
    int lat; logic [31:0] rd; logic err;
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_resp_cfg = 2'b00; r_data_cfg = 32'h0000_0005;
    exp_q.push_back(32'h5); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
    do_txn(1'b0, 32'h0C20_0004, 32'h0, 4'h0, lat, rd, err);
    score("read_zero_wait", lat, rd, err);
    vectors++;
    if (ar_seen !== 32'h0C20_0004) begin miscompares++; $display("FAIL read_araddr got %h want 0c200004", ar_seen); end
  endtask

  task automatic test_write_split();
    int lat; logic [31:0] rd; logic err; int b0;
    aw_delay = 2; w_delay = 0; b_resp_cfg = 2'b00;
    awv_cycles = 0; wv_cycles = 0; b0 = b_hs_cnt;
    exp_q.push_back(32'h0); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3 + aw_delay);
    do_txn(1'b1, 32'h0C00_0010, 32'h0000_0007, 4'hF, lat, rd, err);
    score("write_split", lat, rd, err);
    vectors++;
    if (awv_cycles !== 3) begin miscompares++; $display("FAIL write_awvalid_cycles got %0d want 3", awv_cycles); end
    vectors++;
    if (wv_cycles !== 1) begin miscompares++; $display("FAIL write_wvalid_cycles got %0d want 1", wv_cycles); end
    vectors++;
    if (b_hs_cnt - b0 !== 1) begin miscompares++; $display("FAIL write_b_count got %0d want 1", b_hs_cnt - b0); end
    vectors++;
    if ({aw_seen, w_seen, ws_seen} !== {32'h0C00_0010, 32'h7, 4'hF}) begin
      miscompares++; $display("FAIL write_fields aw=%h wd=%h ws=%h want 0c000010 7 f", aw_seen, w_seen, ws_seen);
    end
    aw_delay = 0;
  endtask

  task automatic test_slave_error();
    int lat; logic [31:0] rd; logic err;
    r_resp_cfg = 2'b10; r_data_cfg = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(3);
    do_txn(1'b0, 32'h0C00_0100, 32'h0, 4'h0, lat, rd, err);
    score("read_slverr", lat, rd, err);
    b_resp_cfg = 2'b11;
    exp_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(3);
    do_txn(1'b1, 32'h0C00_0104, 32'h1234_5678, 4'h3, lat, rd, err);
    score("write_decerr", lat, rd, err);
    r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
  endtask

  task automatic test_out_of_window();
    int lat; logic [31:0] rd; logic err;
    logic [31:0] addrs[3];
    addrs[0] = 32'h1000_0000; addrs[1] = BASE - 32'd4; addrs[2] = BASE + WIN;
    foreach (addrs[i]) begin
      arv_cycles = 0; awv_cycles = 0;
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
      do_txn(i == 2, addrs[i], 32'hFFFF_FFFF, 4'hF, lat, rd, err);
      score("out_of_window", lat, rd, err);
      vectors++;
      if (arv_cycles + awv_cycles !== 0) begin
        miscompares++; $display("FAIL oow_bus_activity addr=%h got %0d valid cycles want 0", addrs[i], arv_cycles + awv_cycles);
      end
    end
    // Last word of the window is still legal.
    r_data_cfg = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
    do_txn(1'b0, BASE + WIN - 32'd4, 32'h0, 4'h0, lat, rd, err);
    score("window_top", lat, rd, err);
  endtask

  task automatic test_back_to_back();
    int cyc; bit got; int ar0;
    r_data_cfg = 32'h0000_00B2; ar0 = ar_hs_cnt;
    req_we = 1'b1; req_addr = 32'h0C00_0013; req_wdata = 32'h0000_00B1; req_wstrb = 4'h1; req_valid = 1'b1;
    @(posedge clk); #1;
    // Second request (a read) held high from the cycle right after the first accept.
    req_we = 1'b0; req_addr = 32'h0C00_0020;
    cyc = 1; got = 0;
    while (!got && cyc < 50) begin
      if (rsp_valid) got = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("FAIL b2b_first_latency got %0d want 3", cyc); end
    vectors++;
    if (aw_seen !== 32'h0C00_0010) begin miscompares++; $display("FAIL b2b_misaligned_awaddr got %h want 0c000010", aw_seen); end
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_in_resp got %b want 0", req_ready); end
    @(posedge clk); #1; cyc++;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_resp got %b want 1", req_ready); end
    @(posedge clk); #1; cyc++;
    req_valid = 1'b0;
    got = 0;
    while (!got && cyc < 60) begin
      if (rsp_valid) got = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    vectors++;
    if (cyc !== 7 || rsp_rdata !== 32'hB2) begin
      miscompares++; $display("FAIL b2b_second got cycle %0d data %h want 7 000000b2", cyc, rsp_rdata);
    end
    vectors++;
    if (ar_hs_cnt - ar0 !== 1) begin miscompares++; $display("FAIL b2b_single_accept got %0d reads want 1", ar_hs_cnt - ar0); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic err;
    logic we; logic [31:0] addr, dat; logic [1:0] resp;
    for (int n = 0; n < 10; n++) begin
      we = 1'($urandom_range(0, 1));
      addr = BASE + ($urandom_range(0, 32'h00FF_FFFF) << 2);
      dat = $urandom;
      resp = 2'($urandom_range(0, 3));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      b_resp_cfg = resp; r_resp_cfg = resp; r_data_cfg = dat;
      exp_q.push_back((we || resp[1]) ? 32'h0 : dat);
      exp_err_q.push_back(resp[1]);
      exp_lat_q.push_back(we ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) : 3 + ar_delay);
      do_txn(we, addr, dat, 4'hF, lat, rd, err);
      score("random", lat, rd, err);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    int r0; bit saw;
    ar_delay = 1000; r0 = rsp_cnt;
    req_we = 1'b0; req_addr = 32'h0C00_0040; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (arvalid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_arvalid_held got %b want 1", arvalid); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      miscompares++; $display("FAIL rst_mid_valids_drop got %b want 00000", {arvalid, rready, awvalid, wvalid, bready});
    end
    ar_delay = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req_ready got %b want 1", req_ready); end
    saw = 0;
    repeat (10) begin @(posedge clk); #1; if (rsp_valid) saw = 1; end
    vectors++;
    if (saw || rsp_cnt != r0) begin miscompares++; $display("FAIL rst_mid_no_rsp got pulse=%b count=%0d want none", saw, rsp_cnt - r0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_read_zero_wait();
    test_write_split();
    test_slave_error();
    test_out_of_window();
    test_back_to_back();
    test_random();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
